mmio_router: RTL and testbench
==============================

MMIO_ROUTER -- requirements
Module: mmio_router

Interface
REQ-001 SHALL have parameter CLINT_BASE, default 32'h9000_0000, base address of the CLINT region.
REQ-002 SHALL have parameter CLINT_MASK, default 32'hFFFF_0000; an address hits CLINT when (addr & CLINT_MASK) == CLINT_BASE.
REQ-003 SHALL have ports clk (in, 1) and resetb (in, 1); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have master write ports m_wready (in, 1, write request), m_wvalid (out, 1, write accepted), m_waddr (in, 32), m_wdata (in, 32) and m_wstrb (in, 4).
REQ-005 SHALL have master read ports m_rready (in, 1, read request), m_raddr (in, 32), m_rstall (out, 1, request not accepted), m_rvalid (out, 1, response), m_rresp (out, 1) and m_rdata (out, 32).
REQ-006 SHALL have slave port sets c_* (CLINT) and d_* (memory), each with the master set's signals at mirrored direction, except m_rstall, which has no slave counterpart.
REQ-007 SHALL have output rd_err (out, 1), a sticky flag for an unexpected slave read response.

Function
REQ-008 Write routing SHALL be combinational:
- c_wready = m_wready & hit(m_waddr); d_wready = m_wready & !hit(m_waddr).
- Both slaves receive waddr, wdata and wstrb unchanged.
- m_wvalid SHALL equal the selected slave's wvalid.
REQ-009 A read request is accepted in any cycle with m_rready=1 and m_rstall=0.
- The request is forwarded the same cycle: c_rready or d_rready, selected by hit(m_raddr), with raddr unchanged.
- If m_rstall=1, neither slave rready SHALL assert.
REQ-010 Ordering state SHALL be a 2-entry FIFO of destination bits (0=D, 1=C) with a count of 0..2.
- Push on accept; pop on m_rvalid.
- Push and pop in the same cycle SHALL leave count unchanged.
REQ-011 m_rstall SHALL be 1 exactly when count==2 (registered state; no same-cycle pop bypass).
REQ-012 Each slave SHALL have a 1-entry hold buffer storing {rresp, rdata} plus a valid bit.
REQ-013 Response delivery each cycle, where H is the head destination, SHALL follow this priority:
- (a) hold[H] valid: drive m_rvalid=1 from hold[H] and clear it.
- (b) otherwise H's slave rvalid=1: drive m_rvalid=1 with its data the same cycle (zero added latency).
- (c) otherwise m_rvalid=0.
REQ-014 A slave rvalid not consumed by REQ-013 SHALL be written into that slave's hold, provided an outstanding FIFO entry targets that slave and is not yet held.
- If hold[H] is cleared in the same cycle, the H slave's rvalid refills hold[H].
REQ-015 A slave rvalid with no matching outstanding entry, or arriving while its hold is full and not draining, SHALL be dropped and set rd_err=1 until reset.
REQ-016 Responses to the master SHALL always be returned in request order, regardless of slave response order.
REQ-017 m_rvalid SHALL be 0 when count==0.
REQ-018 m_rresp and m_rdata are don't-care when m_rvalid=0 and SHALL be driven to 0.

Reset
REQ-019 While resetb=0 the block SHALL hold:
- count=0, FIFO cleared, both holds invalid, rd_err=0.
- m_rvalid=0 and m_rstall=0; slave rready outputs follow REQ-009.
REQ-020 Reset asserted mid-transaction SHALL discard all outstanding reads; slave responses after release SHALL be treated per REQ-015.

Verification
REQ-021 Write m_waddr=32'h9000_4000, m_wdata=32'h1234, c_wvalid=1 -> c_wready=1, d_wready=0, m_wvalid=1 in the same cycle.
REQ-022 Read 0x0000_0100 (D), then 0x9000_BFF8 (C); C responds first with 32'hAAAA, D responds 2 cycles later with 32'h5555 -> m_rvalid pulses deliver 32'h5555 and then 32'hAAAA on the next cycle.
REQ-023 Two reads outstanding, no responses -> m_rstall=1 and a third m_rready produces no slave rready; after one response, m_rstall=0 on the next cycle.
REQ-024 Single read to D with d_rvalid on the following cycle, d_rdata=32'hDEAD_BEEF, d_rresp=1 -> m_rvalid=1 with m_rdata=32'hDEAD_BEEF and m_rresp=1 in that same cycle.
REQ-025 c_rvalid=1 with count==0 -> m_rvalid=0 and rd_err=1, which stays 1 until resetb=0.
REQ-026 resetb pulsed low with 2 reads outstanding -> count=0, m_rstall=0 and m_rvalid=0 immediately; a new read is accepted the cycle after release.

Source files
------------

// File: rtl/mmio_router.sv
// mmio_router: routes master MMIO writes/reads to CLINT (c_*) or memory (d_*) slaves
// and returns read responses to the master in request order.
// Ports:
//   clk, resetb            clock, asynchronous active-low reset
//   m_w*                   master write: m_wready request in, m_wvalid accept out
//   m_r*                   master read: m_rready request in, m_rstall/m_rvalid/m_rresp/m_rdata out
//   c_w*/c_r*, d_w*/d_r*   slave ports, mirrored directions of the master set
//   rd_err                 sticky flag for an unexpected slave read response
module mmio_router #(
   parameter logic [31:0] CLINT_BASE = 32'h9000_0000,
   parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        m_wready,
   output logic        m_wvalid,
   input  logic [31:0] m_waddr,
   input  logic [31:0] m_wdata,
   input  logic [3:0]  m_wstrb,
   input  logic        m_rready,
   input  logic [31:0] m_raddr,
   output logic        m_rstall,
   output logic        m_rvalid,
   output logic        m_rresp,
   output logic [31:0] m_rdata,
   output logic        c_wready,
   input  logic        c_wvalid,
   output logic [31:0] c_waddr,
   output logic [31:0] c_wdata,
   output logic [3:0]  c_wstrb,
   output logic        c_rready,
   output logic [31:0] c_raddr,
   input  logic        c_rvalid,
   input  logic        c_rresp,
   input  logic [31:0] c_rdata,
   output logic        d_wready,
   input  logic        d_wvalid,
   output logic [31:0] d_waddr,
   output logic [31:0] d_wdata,
   output logic [3:0]  d_wstrb,
   output logic        d_rready,
   output logic [31:0] d_raddr,
   input  logic        d_rvalid,
   input  logic        d_rresp,
   input  logic [31:0] d_rdata,
   output logic        rd_err
);
   // Index 1 = CLINT, index 0 = memory throughout; fifo_q[0] is the head.
   logic [1:0]       count_q, count_d;
   logic [1:0]       fifo_q, fifo_d;
   logic [1:0]       hold_v_q, hold_v_d;
   logic [1:0][32:0] hold_q, hold_d;
   logic             rd_err_q, rd_err_d;
   logic             w_hit, r_hit, accept, head, head_held, pop;
   logic [1:0]       rv, consumed, drain, store;
   logic [1:0][32:0] rsp;
   logic [1:0][1:0]  n;
   logic [32:0]      out;

   always_comb begin
      w_hit = (m_waddr & CLINT_MASK) == CLINT_BASE;
      c_wready = m_wready && w_hit;
      d_wready = m_wready && !w_hit;
      m_wvalid = w_hit ? c_wvalid : d_wvalid;
      c_waddr = m_waddr;
      c_wdata = m_wdata;
      c_wstrb = m_wstrb;
      d_waddr = m_waddr;
      d_wdata = m_wdata;
      d_wstrb = m_wstrb;
   end

   always_comb begin
      rv = {c_rvalid, d_rvalid};
      rsp = {{c_rresp, c_rdata}, {d_rresp, d_rdata}};
      r_hit = (m_raddr & CLINT_MASK) == CLINT_BASE;
      m_rstall = count_q == 2'd2;
      accept = m_rready && !m_rstall;
      c_rready = accept && r_hit;
      d_rready = accept && !r_hit;
      c_raddr = m_raddr;
      d_raddr = m_raddr;
      head = fifo_q[0];
      head_held = hold_v_q[head];
      m_rvalid = (count_q != 2'd0) && (head_held || rv[head]);
      out = head_held ? hold_q[head] : rsp[head];
      {m_rresp, m_rdata} = m_rvalid ? out : 33'd0;
      pop = m_rvalid;
      // outstanding entries per destination
      n[1] = 2'(count_q != 2'd0 && fifo_q[0]) + 2'(count_q == 2'd2 && fifo_q[1]);
      n[0] = count_q - n[1];
      hold_v_d = hold_v_q;
      hold_d = hold_q;
      rd_err_d = rd_err_q;
      for (int s = 0; s < 2; s++) begin
         consumed[s] = pop && !head_held && head == 1'(s);
         drain[s] = pop && head_held && head == 1'(s);
         // store only if some outstanding entry for this slave has no response yet
         store[s] = rv[s] && !consumed[s] && (!hold_v_q[s] || drain[s]) && n[s] > {1'b0, hold_v_q[s]};
         hold_v_d[s] = store[s] || (hold_v_q[s] && !drain[s]);
         if (store[s]) hold_d[s] = rsp[s];
         if (rv[s] && !consumed[s] && !store[s]) rd_err_d = 1'b1;
      end
      fifo_d = pop ? {1'b0, fifo_q[1]} : fifo_q;
      if (accept) begin
         if (count_q == 2'(pop)) fifo_d[0] = r_hit;
         else fifo_d[1] = r_hit;
      end
      count_d = count_q + 2'(accept) - 2'(pop);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         count_q <= '0;
         fifo_q <= '0;
         hold_v_q <= '0;
         hold_q <= '0;
         rd_err_q <= 1'b0;
      end else begin
         count_q <= count_d;
         fifo_q <= fifo_d;
         hold_v_q <= hold_v_d;
         hold_q <= hold_d;
         rd_err_q <= rd_err_d;
      end
   end

   assign rd_err = rd_err_q;
endmodule

// File: tb/tb_mmio_router.sv
// tb_mmio_router: scoreboard bench for mmio_router with directed scenarios and random traffic
module tb_mmio_router;
   logic clk = 0, resetb = 0;
   logic m_wready = 0, m_wvalid, m_rready = 0, m_rstall, m_rvalid, m_rresp;
   logic [31:0] m_waddr = 0, m_wdata = 0, m_raddr = 0, m_rdata;
   logic [3:0] m_wstrb = 0, c_wstrb, d_wstrb;
   logic c_wready, c_wvalid = 0, c_rready, c_rvalid = 0, c_rresp = 0;
   logic d_wready, d_wvalid = 0, d_rready, d_rvalid = 0, d_rresp = 0;
   logic [31:0] c_waddr, c_wdata, c_raddr, c_rdata = 0, d_waddr, d_wdata, d_raddr, d_rdata = 0;
   logic rd_err;

   int checks = 0, errors = 0, cyc = 0, nid = 0;
   logic [32:0] rsp_of [4096];
   int iss [4096];
   bit responded [4096];
   int exp_q[$], sq_c[$], sq_d[$];
   bit exp_stall = 0, exp_err = 0, err_pending = 0;

   always #5 clk = ~clk;

   mmio_router dut (
      .clk(clk), .resetb(resetb),
      .m_wready(m_wready), .m_wvalid(m_wvalid), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_rready(m_rready), .m_raddr(m_raddr), .m_rstall(m_rstall), .m_rvalid(m_rvalid),
      .m_rresp(m_rresp), .m_rdata(m_rdata),
      .c_wready(c_wready), .c_wvalid(c_wvalid), .c_waddr(c_waddr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
      .c_rready(c_rready), .c_raddr(c_raddr), .c_rvalid(c_rvalid), .c_rresp(c_rresp), .c_rdata(c_rdata),
      .d_wready(d_wready), .d_wvalid(d_wvalid), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rready(d_rready), .d_raddr(d_raddr), .d_rvalid(d_rvalid), .d_rresp(d_rresp), .d_rdata(d_rdata),
      .rd_err(rd_err)
   );

   function automatic bit hit(input logic [31:0] a);
      return (a & 32'hFFFF_0000) == 32'h9000_0000;
   endfunction

   function automatic logic [31:0] rand_addr();
      return ($urandom % 2) ? (32'h9000_0000 | ($urandom & 32'hFFFF)) : ($urandom & 32'h7FFF_FFFF);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle of stimulus: slaves answer their oldest request if asked, then the master issues.
   task automatic step(input bit rd, input logic [31:0] ra, input bit rc, input bit rdd,
                       input bit wr, input logic [31:0] wa);
      int id;
      @(posedge clk);
      #1;
      cyc++;
      if (err_pending) begin
         exp_err = 1;
         err_pending = 0;
      end
      c_rvalid = 0; d_rvalid = 0;
      c_rdata = $urandom; d_rdata = $urandom; c_rresp = 1'($urandom); d_rresp = 1'($urandom);
      if (rc && sq_c.size() > 0 && iss[sq_c[0]] < cyc) begin
         id = sq_c.pop_front();
         c_rvalid = 1; {c_rresp, c_rdata} = rsp_of[id]; responded[id] = 1;
      end
      if (rdd && sq_d.size() > 0 && iss[sq_d[0]] < cyc) begin
         id = sq_d.pop_front();
         d_rvalid = 1; {d_rresp, d_rdata} = rsp_of[id]; responded[id] = 1;
      end
      exp_stall = exp_q.size() == 2;
      m_rready = rd; m_raddr = ra;
      if (rd && !exp_stall) begin
         id = nid;
         nid = (nid + 1) % 4096;
         rsp_of[id] = {1'($urandom), 32'($urandom)};
         responded[id] = 0;
         iss[id] = cyc;
         exp_q.push_back(id);
         if (hit(ra)) sq_c.push_back(id);
         else sq_d.push_back(id);
      end
      m_wready = wr; m_waddr = wa; m_wdata = $urandom; m_wstrb = 4'($urandom);
      c_wvalid = 1'($urandom); d_wvalid = 1'($urandom);
   endtask

   // Monitor: head of the order queue is due once its slave has answered.
   always @(negedge clk) begin
      bit ev;
      int id;
      chk("wroute", {c_wready, d_wready, m_wvalid},
          {m_wready && hit(m_waddr), m_wready && !hit(m_waddr), hit(m_waddr) ? c_wvalid : d_wvalid});
      chk("wpass", {c_waddr, c_wdata, c_wstrb, d_waddr, d_wdata, d_wstrb},
          {m_waddr, m_wdata, m_wstrb, m_waddr, m_wdata, m_wstrb});
      chk("rstall", m_rstall, exp_stall);
      chk("rready", {c_rready, d_rready, c_raddr, d_raddr},
          {m_rready && !exp_stall && hit(m_raddr), m_rready && !exp_stall && !hit(m_raddr), m_raddr, m_raddr});
      ev = exp_q.size() > 0 && responded[exp_q[0]];
      chk("rvalid", m_rvalid, ev);
      if (ev) begin
         id = exp_q.pop_front();
         chk("rdata", {m_rresp, m_rdata}, rsp_of[id]);
      end else chk("ridle", {m_rresp, m_rdata}, 0);
      chk("rd_err", rd_err, exp_err);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 resetb = 1;
      // write routed to CLINT
      step(0, 0, 0, 0, 1, 32'h9000_4000);
      m_wdata = 32'h1234; c_wvalid = 1;
      #1 chk("wr_clint", {c_wready, d_wready, m_wvalid, c_wdata}, {3'b101, 32'h1234});
      // single D read answered next cycle, zero added latency
      step(1, 32'h100, 0, 0, 0, 0);
      rsp_of[exp_q[$]] = {1'b1, 32'hDEAD_BEEF};
      step(0, 0, 0, 1, 0, 0);
      #1 chk("d_zero_lat", {m_rvalid, m_rresp, m_rdata}, {2'b11, 32'hDEAD_BEEF});
      // out-of-order slave answers, in-order delivery
      step(1, 32'h100, 0, 0, 0, 0);
      rsp_of[exp_q[$]] = {1'b0, 32'h5555};
      step(1, 32'h9000_BFF8, 0, 0, 0, 0);
      rsp_of[exp_q[$]] = {1'b0, 32'hAAAA};
      step(0, 0, 1, 0, 0, 0);
      #1 chk("c_held", m_rvalid, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      #1 chk("order_1st", {m_rvalid, m_rdata}, {1'b1, 32'h5555});
      step(0, 0, 0, 0, 0, 0);
      #1 chk("order_2nd", {m_rvalid, m_rdata}, {1'b1, 32'hAAAA});
      // stall with two outstanding
      step(1, 32'h200, 0, 0, 0, 0);
      step(1, 32'h9000_0010, 0, 0, 0, 0);
      step(1, 32'h300, 0, 0, 0, 0);
      #1 chk("stall_full", {m_rstall, c_rready, d_rready}, 3'b100);
      step(0, 0, 0, 1, 0, 0);
      step(1, 32'h300, 0, 0, 0, 0);
      #1 chk("stall_release", {m_rstall, d_rready}, 2'b01);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      // unexpected response with nothing outstanding
      step(0, 0, 0, 0, 0, 0);
      c_rvalid = 1; c_rdata = 32'h77; err_pending = 1;
      #1 chk("spurious_rvalid", m_rvalid, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0);
      #1 chk("rd_err_sticky", rd_err, 1);
      // reset with two outstanding reads
      step(1, 32'h100, 0, 0, 0, 0);
      step(1, 32'h9000_0000, 0, 0, 0, 0);
      #1 resetb = 0;
      exp_q.delete(); sq_c.delete(); sq_d.delete();
      exp_err = 0; err_pending = 0; exp_stall = 0; m_rready = 0;
      #1 chk("reset_state", {m_rstall, m_rvalid, rd_err}, 3'b000);
      @(posedge clk);
      #1 resetb = 1;
      step(1, 32'h9000_0020, 0, 0, 0, 0);
      #1 chk("post_reset_accept", c_rready, 1);
      step(0, 0, 1, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 2000; i++)
         step(1'($urandom), rand_addr(), ($urandom % 3) == 0, ($urandom % 3) == 0, 1'($urandom), rand_addr());
      for (int i = 0; i < 100 && exp_q.size() > 0; i++) step(0, 0, 1, 1, 0, 0);
      @(negedge clk);
      #1 chk("drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
